// File: rtl/factorial_bus_if.sv
// Memory-mapped front end for the factorial accelerator: holds the operand,
// issues a one-cycle go pulse, captures the result and reports sticky status.
module factorial_bus_if #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        fact_go,
  output logic [3:0]  fact_n,
  input  logic [31:0] fact_out,
  input  logic        fact_done,
  input  logic        fact_error,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT
  } state_e;

  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  // Last timer value that still counts as "in time"; TIMEOUT stays within 2..255.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  n_q, n_d;
  logic        ie_q, ie_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;
  logic [31:0] result_q, result_d;
  logic [7:0]  timer_q, timer_d;

  logic        wr_n;
  logic        wr_ctrl;
  logic        launch_req;
  logic        unused_wd;

  assign wr_n       = we && (a == ADDR_N);
  assign wr_ctrl    = we && (a == ADDR_CTRL);
  assign launch_req = wr_ctrl && wd[0] && (state_q == S_IDLE);
  assign unused_wd  = ^wd[31:4];

  // NOTE: every next-state variable is defaulted to its register first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    ie_d     = ie_q;
    done_d   = done_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    timer_d  = timer_q;

    if (wr_ctrl) begin
      ie_d = wd[1];
    end

    unique case (state_q)
      S_IDLE: begin
        if (wr_n) begin
          n_d = wd[3:0];
        end
        if (launch_req) begin
          state_d  = S_LAUNCH;
          done_d   = 1'b0;
          err_d    = 1'b0;
          tmo_d    = 1'b0;
          result_d = '0;
          timer_d  = '0;
        end
      end

      S_LAUNCH: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Error wins over done; a response on the final cycle beats the watchdog.
        if (fact_error) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_IDLE;
        end else if (fact_done) begin
          done_d   = 1'b1;
          result_d = fact_out;
          state_d  = S_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          err_d    = 1'b1;
          tmo_d    = 1'b1;
          result_d = '0;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      result_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      ie_q     <= ie_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      result_q <= result_d;
      timer_q  <= timer_d;
    end
  end

  assign fact_go = (state_q == S_LAUNCH);
  assign busy    = (state_q != S_IDLE);
  assign fact_n  = n_q;
  assign irq     = ie_q & (done_q | err_q);

  always_comb begin
    rd = '0;
    unique case (a)
      ADDR_N:      rd = {28'b0, n_q};
      ADDR_CTRL:   rd = {30'b0, ie_q, busy};
      ADDR_STATUS: rd = {28'b0, tmo_q, busy, err_q, done_q};
      ADDR_RESULT: rd = result_q;
      default:     rd = '0;
    endcase
  end

endmodule

// File: tb/tb_factorial_bus_if.sv
// Directed bench for factorial_bus_if: the CPU side is driven by tasks and the
// accelerator is a hand-driven stub; expected values are worked out by hand.
`timescale 1ns/1ps
module tb_factorial_bus_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        fact_go;
  logic [3:0]  fact_n;
  logic [31:0] fact_out;
  logic        fact_done;
  logic        fact_error;
  logic        busy;
  logic        irq;

  int errors = 0;
  int checks = 0;

  factorial_bus_if #(.TIMEOUT(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .a          (a),
    .wd         (wd),
    .rd         (rd),
    .fact_go    (fact_go),
    .fact_n     (fact_n),
    .fact_out   (fact_out),
    .fact_done  (fact_done),
    .fact_error (fact_error),
    .busy       (busy),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    we = 1'b1;
    a  = addr;
    wd = data;
    step();
    we = 1'b0;
    wd = '0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] v);
    a = addr;
    #1;
    v = rd;
  endtask

  task automatic respond(input logic done, input logic err, input logic [31:0] val);
    fact_done  = done;
    fact_error = err;
    fact_out   = val;
    step();
    fact_done  = 1'b0;
    fact_error = 1'b0;
    fact_out   = '0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), v);
      checks++;
      if (v !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd[%0d]: got %h expected %h", i, v, 32'h0);
      end
    end
    checks++;
    if ({fact_go, busy, irq, fact_n} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: go=%b busy=%b irq=%b n=%h expected all 0",
               fact_go, busy, irq, fact_n);
    end
  endtask

  task automatic test_done();
    logic [31:0] v;
    bus_write(2'd0, 32'd5);
    bus_read(2'd0, v);
    checks++;
    if (v !== 32'd5) begin errors++; $display("FAIL n_readback: got %h expected %h", v, 32'd5); end
    bus_write(2'd1, 32'd1);
    checks++;
    if ({fact_go, busy} !== 2'b11) begin
      errors++;
      $display("FAIL launch_go: go=%b busy=%b expected go=1 busy=1", fact_go, busy);
    end
    step();
    checks++;
    if ({fact_go, busy} !== 2'b01) begin
      errors++;
      $display("FAIL go_one_cycle: go=%b busy=%b expected go=0 busy=1", fact_go, busy);
    end
    step();
    step();
    respond(1'b1, 1'b0, 32'd120);
    bus_read(2'd3, v);
    checks++;
    if (v !== 32'd120) begin errors++; $display("FAIL done_result: got %0d expected 120", v); end
    bus_read(2'd2, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL done_status: got %h expected %h", v, 32'h1); end
    checks++;
    if ({busy, irq} !== 2'b00) begin
      errors++;
      $display("FAIL done_idle: busy=%b irq=%b expected 0 0", busy, irq);
    end
  endtask

  task automatic test_error();
    logic [31:0] v;
    bus_write(2'd0, 32'd13);
    bus_write(2'd1, 32'd3);
    bus_read(2'd2, v);
    checks++;
    if (v !== 32'h4) begin errors++; $display("FAIL launch_clears_status: got %h expected %h", v, 32'h4); end
    step();
    respond(1'b0, 1'b1, 32'hDEAD_BEEF);
    bus_read(2'd2, v);
    checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL err_status: got %h expected %h", v, 32'h2); end
    bus_read(2'd3, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL err_result: got %h expected %h", v, 32'h0); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL err_irq: got %b expected 1", irq); end
    bus_read(2'd1, v);
    checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL ctrl_read: got %h expected %h", v, 32'h2); end
  endtask

  task automatic test_ignored_writes();
    logic [31:0] v;
    bus_write(2'd1, 32'd1);
    step();
    bus_write(2'd0, 32'd7);
    checks++;
    if (fact_go !== 1'b0) begin errors++; $display("FAIL wait_no_go_a: got %b expected 0", fact_go); end
    bus_write(2'd1, 32'd1);
    checks++;
    if (fact_go !== 1'b0) begin errors++; $display("FAIL wait_no_go_b: got %b expected 0", fact_go); end
    checks++;
    if (fact_n !== 4'd13) begin errors++; $display("FAIL wait_fact_n: got %0d expected 13", fact_n); end
    respond(1'b1, 1'b0, 32'h1234);
    bus_read(2'd0, v);
    checks++;
    if (v !== 32'd13) begin errors++; $display("FAIL n_unchanged: got %0d expected 13", v); end
    bus_read(2'd2, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL second_done_status: got %h expected %h", v, 32'h1); end
    bus_write(2'd1, 32'd1);
    bus_read(2'd2, v);
    checks++;
    if (v !== 32'h4) begin errors++; $display("FAIL relaunch_status: got %h expected %h", v, 32'h4); end
    bus_read(2'd3, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL relaunch_result: got %h expected %h", v, 32'h0); end
    step();
    respond(1'b1, 1'b0, 32'd6);
  endtask

  task automatic test_timeout();
    logic [31:0] v;
    int wait_cycles;
    bus_write(2'd1, 32'd1);
    wait_cycles = 0;
    step();
    while (busy === 1'b1 && wait_cycles < 300) begin
      wait_cycles++;
      step();
    end
    checks++;
    if (wait_cycles !== 64) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d expected 64", wait_cycles);
    end
    bus_read(2'd2, v);
    checks++;
    if (v !== 32'hA) begin errors++; $display("FAIL timeout_status: got %h expected %h", v, 32'hA); end
    bus_read(2'd3, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL timeout_result: got %h expected %h", v, 32'h0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL timeout_irq_masked: got %b expected 0", irq); end
  endtask

  task automatic test_done_and_error();
    logic [31:0] v;
    bus_write(2'd1, 32'd1);
    step();
    respond(1'b1, 1'b1, 32'd99);
    bus_read(2'd2, v);
    checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL both_status: got %h expected %h", v, 32'h2); end
    bus_read(2'd3, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL both_result: got %h expected %h", v, 32'h0); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] v;
    bus_write(2'd1, 32'd3);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({fact_go, busy, irq, fact_n} !== 7'b0) begin
      errors++;
      $display("FAIL midrun_outputs: go=%b busy=%b irq=%b n=%h expected all 0",
               fact_go, busy, irq, fact_n);
    end
    bus_read(2'd0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL midrun_n: got %h expected %h", v, 32'h0); end
    fact_done = 1'b1;
    fact_out  = 32'd55;
    step();
    step();
    fact_done = 1'b0;
    fact_out  = '0;
    bus_read(2'd2, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL stale_done_status: got %h expected %h", v, 32'h0); end
    bus_read(2'd3, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL stale_done_result: got %h expected %h", v, 32'h0); end
  endtask

  initial begin
    reset      = 1'b1;
    we         = 1'b0;
    a          = '0;
    wd         = '0;
    fact_out   = '0;
    fact_done  = 1'b0;
    fact_error = 1'b0;
    #1;
    test_reset();
    test_done();
    test_error();
    test_ignored_writes();
    test_timeout();
    test_done_and_error();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
